// File: rtl/thread_sched_pkg.sv
// Shared configuration, thread-state type and helpers for the barrel-thread scheduler.
// cpu_config holds the thread geometry, cpu_types the state encoding.
package cpu_config;
  localparam int NUM_THREADS = 4;
  localparam int TID_W       = 2;
endpackage

package cpu_types;
  typedef enum logic [1:0] {
    TS_DISABLED = 2'd0,
    TS_READY    = 2'd1,
    TS_WAIT     = 2'd2,
    TS_HALTED   = 2'd3
  } thread_state_e;
endpackage

package thread_sched_pkg;
  import cpu_types::*;

  localparam int CNT_W = 4;

  localparam logic [1:0] ST_DISABLED = TS_DISABLED;
  localparam logic [1:0] ST_READY    = TS_READY;
  localparam logic [1:0] ST_WAIT     = TS_WAIT;
  localparam logic [1:0] ST_HALTED   = TS_HALTED;

  // A thread still has work pending while it is READY or WAIT.
  function automatic logic is_active(input logic [1:0] st);
    return (st == ST_READY) || (st == ST_WAIT);
  endfunction
endpackage

// File: rtl/thread_sched_if.sv
// Scheduler bus: thread control events from the pipeline and issue/status back to it.
interface thread_sched_if import cpu_config::*;;
  logic [NUM_THREADS-1:0]   thread_en;
  logic                     block_valid;
  logic [TID_W-1:0]         block_tid;
  logic [3:0]               block_cycles;
  logic                     wake_valid;
  logic [TID_W-1:0]         wake_tid;
  logic                     halt_valid;
  logic [TID_W-1:0]         halt_tid;
  logic [TID_W-1:0]         thread_id;
  logic                     issue_valid;
  logic [2*NUM_THREADS-1:0] thread_state;
  logic                     all_halted;

  modport master (
    output thread_en, block_valid, block_tid, block_cycles,
    output wake_valid, wake_tid, halt_valid, halt_tid,
    input  thread_id, issue_valid, thread_state, all_halted
  );

  modport slave (
    input  thread_en, block_valid, block_tid, block_cycles,
    input  wake_valid, wake_tid, halt_valid, halt_tid,
    output thread_id, issue_valid, thread_state, all_halted
  );
endinterface

// File: rtl/thread_sched_rr_arbiter.sv
// 4-way round-robin find-first: first requester after ptr, wrapping back to ptr itself.
module rr_arbiter import cpu_config::*; (
  input  logic [NUM_THREADS-1:0] req,
  input  logic [TID_W-1:0]       ptr,
  output logic                   grant_valid,
  output logic [TID_W-1:0]       grant_id
);
  logic [TID_W-1:0] idx;

  // Scan farthest-first so the nearest requester after ptr is written last and wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = ptr;
    idx         = ptr;
    for (int k = NUM_THREADS; k >= 1; k--) begin
      idx = ptr + TID_W'(k);
      if (req[idx]) begin
        grant_valid = 1'b1;
        grant_id    = idx;
      end
    end
  end
endmodule

// File: rtl/thread_sched.sv
// Per-thread READY/WAIT/HALTED/DISABLED tracking with a registered round-robin issue
// selection feeding the fetch stage.
module thread_sched import cpu_config::*, thread_sched_pkg::*; (
  input logic           clk,
  input logic           rst,
  thread_sched_if.slave bus
);
  logic [1:0]             state_q [NUM_THREADS];
  logic [1:0]             state_d [NUM_THREADS];
  logic [CNT_W-1:0]       cnt_q   [NUM_THREADS];
  logic [CNT_W-1:0]       cnt_d   [NUM_THREADS];
  logic [NUM_THREADS-1:0] ready;
  logic [NUM_THREADS-1:0] halt_hit;
  logic [NUM_THREADS-1:0] block_hit;
  logic [NUM_THREADS-1:0] wake_hit;
  logic [TID_W-1:0]       rr_ptr_q;
  logic [TID_W-1:0]       thread_id_p0;
  logic                   vld_p0;
  logic                   grant_valid;
  logic [TID_W-1:0]       grant_id;
  logic                   any_active;
  logic [2*NUM_THREADS-1:0] state_flat;

  always_comb begin
    ready      = '0;
    halt_hit   = '0;
    block_hit  = '0;
    wake_hit   = '0;
    any_active = 1'b0;
    state_flat = '0;
    for (int t = 0; t < NUM_THREADS; t++) begin
      ready[t]     = (state_q[t] == ST_READY);
      halt_hit[t]  = bus.halt_valid  && (bus.halt_tid  == TID_W'(t));
      block_hit[t] = bus.block_valid && (bus.block_tid == TID_W'(t));
      wake_hit[t]  = bus.wake_valid  && (bus.wake_tid  == TID_W'(t));
      any_active   = any_active | is_active(state_q[t]);
      state_flat[2*t +: 2] = state_q[t];
    end
  end

  rr_arbiter u_arb (
    .req         (ready),
    .ptr         (rr_ptr_q),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  // Event priority per thread: disable > halt > block > wake > countdown.
  always_comb begin
    for (int t = 0; t < NUM_THREADS; t++) begin
      state_d[t] = state_q[t];
      cnt_d[t]   = cnt_q[t];
      if (!bus.thread_en[t]) begin
        state_d[t] = ST_DISABLED;
        cnt_d[t]   = '0;
      end else begin
        case (state_q[t])
          ST_DISABLED: begin
            state_d[t] = ST_READY;
            cnt_d[t]   = '0;
          end
          ST_READY: begin
            if (halt_hit[t]) begin
              state_d[t] = ST_HALTED;
              cnt_d[t]   = '0;
            end else if (block_hit[t] && (bus.block_cycles != '0)) begin
              state_d[t] = ST_WAIT;
              cnt_d[t]   = bus.block_cycles;
            end
          end
          ST_WAIT: begin
            if (halt_hit[t]) begin
              state_d[t] = ST_HALTED;
              cnt_d[t]   = '0;
            end else if (wake_hit[t] || (cnt_q[t] <= CNT_W'(1))) begin
              state_d[t] = ST_READY;
              cnt_d[t]   = '0;
            end else begin
              cnt_d[t] = cnt_q[t] - CNT_W'(1);
            end
          end
          default: begin
            if (wake_hit[t]) begin
              state_d[t] = ST_READY;
              cnt_d[t]   = '0;
            end
          end
        endcase
      end
    end
  end

  // Stage p0: registered issue selection, made from the pre-update thread states.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int t = 0; t < NUM_THREADS; t++) begin
        state_q[t] <= ST_DISABLED;
        cnt_q[t]   <= '0;
      end
      rr_ptr_q     <= TID_W'(NUM_THREADS - 1);
      thread_id_p0 <= '0;
      vld_p0       <= 1'b0;
    end else begin
      for (int t = 0; t < NUM_THREADS; t++) begin
        state_q[t] <= state_d[t];
        cnt_q[t]   <= cnt_d[t];
      end
      vld_p0 <= grant_valid;
      if (grant_valid) begin
        rr_ptr_q     <= grant_id;
        thread_id_p0 <= grant_id;
      end
    end
  end

  assign bus.thread_id    = thread_id_p0;
  assign bus.issue_valid  = vld_p0;
  assign bus.thread_state = state_flat;
  assign bus.all_halted   = ~any_active;
endmodule

// File: tb/tb_thread_sched.sv
// Directed and randomized bench for thread_sched against an abstract per-thread model.
module tb_thread_sched;
  logic clk = 1'b0;
  logic rst;
  thread_sched_if sif();

  thread_sched u_dut (
    .clk (clk),
    .rst (rst),
    .bus (sif)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Model: 0=DISABLED 1=READY 2=WAIT 3=HALTED; m_rr = last issued thread.
  int m_state [4];
  int m_cnt   [4];
  int m_rr;
  int m_tid;
  int m_iv;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    int sel;
    bit h, b, w;
    if (rst) begin
      for (int t = 0; t < 4; t++) begin
        m_state[t] = 0;
        m_cnt[t]   = 0;
      end
      m_rr = 3; m_tid = 0; m_iv = 0;
      return;
    end
    sel = -1;
    for (int k = 1; k <= 4; k++) begin
      if (sel < 0 && m_state[(m_rr + k) % 4] == 1) sel = (m_rr + k) % 4;
    end
    if (sel >= 0) begin
      m_tid = sel; m_rr = sel; m_iv = 1;
    end else begin
      m_iv = 0;
    end
    for (int t = 0; t < 4; t++) begin
      h = sif.halt_valid  && (int'(sif.halt_tid)  == t);
      b = sif.block_valid && (int'(sif.block_tid) == t);
      w = sif.wake_valid  && (int'(sif.wake_tid)  == t);
      if (!sif.thread_en[t]) begin
        m_state[t] = 0; m_cnt[t] = 0;
      end else if (h && (m_state[t] == 1 || m_state[t] == 2)) begin
        m_state[t] = 3; m_cnt[t] = 0;
      end else if (m_state[t] == 0) begin
        m_state[t] = 1;
      end else if (b && m_state[t] == 1 && sif.block_cycles != 0) begin
        m_state[t] = 2; m_cnt[t] = int'(sif.block_cycles);
      end else if (w && (m_state[t] == 2 || m_state[t] == 3)) begin
        m_state[t] = 1; m_cnt[t] = 0;
      end else if (m_state[t] == 2) begin
        m_cnt[t]--;
        if (m_cnt[t] == 0) m_state[t] = 1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [7:0] es;
    bit ah;
    es = '0;
    ah = 1'b1;
    for (int t = 0; t < 4; t++) begin
      es[2*t +: 2] = 2'(m_state[t]);
      if (m_state[t] == 1 || m_state[t] == 2) ah = 1'b0;
    end
    chk({tag, "_iv"},  {7'b0, sif.issue_valid}, 8'(m_iv));
    chk({tag, "_tid"}, {6'b0, sif.thread_id},   8'(m_tid));
    chk({tag, "_st"},  sif.thread_state,        es);
    chk({tag, "_ah"},  {7'b0, sif.all_halted},  {7'b0, ah});
  endtask

  task automatic cyc(input bit r, input logic [3:0] en,
                     input bit bv, input int bt, input int bc,
                     input bit wv, input int wt,
                     input bit hv, input int ht, input string tag);
    rst              = r;
    sif.thread_en    = en;
    sif.block_valid  = bv;
    sif.block_tid    = 2'(bt);
    sif.block_cycles = 4'(bc);
    sif.wake_valid   = wv;
    sif.wake_tid     = 2'(wt);
    sif.halt_valid   = hv;
    sif.halt_tid     = 2'(ht);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic idle(input logic [3:0] en, input string tag);
    cyc(1'b0, en, 1'b0, 0, 0, 1'b0, 0, 1'b0, 0, tag);
  endtask

  initial begin
    // Reset with enables already high: nothing may leave DISABLED.
    cyc(1'b1, 4'hF, 1'b1, 1, 5, 1'b1, 2, 1'b1, 0, "rst");
    cyc(1'b1, 4'hF, 1'b0, 0, 0, 1'b0, 0, 1'b0, 0, "rst");
    chk("rst_state", sif.thread_state, 8'h00);
    chk("rst_iv", {7'b0, sif.issue_valid}, 8'h00);

    // All enabled: 0,1,2,3,0,... starting one cycle after enable takes effect.
    for (int i = 0; i < 8; i++) begin
      idle(4'hF, "all_en");
      if (i == 0) chk("all_en_first_iv", {7'b0, sif.issue_valid}, 8'h00);
      else        chk("all_en_rot", {6'b0, sif.thread_id}, 8'((i - 1) % 4));
    end

    // Block thread 1 for 3 cycles.
    cyc(1'b0, 4'hF, 1'b1, 1, 3, 1'b0, 0, 1'b0, 0, "blk1");
    chk("blk1_wait0", {6'b0, sif.thread_state[3:2]}, 8'd2);
    for (int j = 1; j < 10; j++) begin
      idle(4'hF, "blk1_run");
      if (j < 3)  chk("blk1_wait", {6'b0, sif.thread_state[3:2]}, 8'd2);
      if (j == 3) chk("blk1_ready", {6'b0, sif.thread_state[3:2]}, 8'd1);
    end

    // Halt all four, then wake thread 2 only.
    for (int t = 0; t < 4; t++) cyc(1'b0, 4'hF, 1'b0, 0, 0, 1'b0, 0, 1'b1, t, "halt");
    for (int j = 0; j < 3; j++) begin
      idle(4'hF, "halted");
      chk("halted_ah", {7'b0, sif.all_halted}, 8'd1);
      chk("halted_iv", {7'b0, sif.issue_valid}, 8'd0);
    end
    cyc(1'b0, 4'hF, 1'b0, 0, 0, 1'b1, 2, 1'b0, 0, "wake2");
    for (int j = 0; j < 4; j++) begin
      idle(4'hF, "only2");
      chk("only2_tid", {6'b0, sif.thread_id}, 8'd2);
      chk("only2_iv", {7'b0, sif.issue_valid}, 8'd1);
    end

    // Same-thread collisions: halt beats block; disable beats wake.
    cyc(1'b0, 4'hF, 1'b0, 0, 0, 1'b1, 1, 1'b0, 0, "wake1");
    cyc(1'b0, 4'hF, 1'b0, 0, 0, 1'b1, 3, 1'b0, 0, "wake3");
    cyc(1'b0, 4'hF, 1'b1, 1, 4, 1'b0, 0, 1'b1, 1, "halt_blk1");
    chk("halt_blk1_st", {6'b0, sif.thread_state[3:2]}, 8'd3);
    cyc(1'b0, 4'hF, 1'b1, 3, 5, 1'b0, 0, 1'b0, 0, "blk3");
    cyc(1'b0, 4'h7, 1'b0, 0, 0, 1'b1, 3, 1'b0, 0, "dis_wake3");
    chk("dis_wake3_st", {6'b0, sif.thread_state[7:6]}, 8'd0);
    idle(4'hF, "reen");

    // Reset mid-WAIT on thread 2 with events pending.
    cyc(1'b0, 4'hF, 1'b1, 2, 7, 1'b0, 0, 1'b0, 0, "blk2_7");
    chk("blk2_7_st", {6'b0, sif.thread_state[5:4]}, 8'd2);
    cyc(1'b1, 4'hF, 1'b1, 0, 3, 1'b1, 2, 1'b1, 1, "rst_wait");
    chk("rst_wait_st", sif.thread_state, 8'h00);
    chk("rst_wait_iv", {7'b0, sif.issue_valid}, 8'd0);
    for (int j = 0; j < 4; j++) idle(4'b0100, "post_rst2");
    chk("post_rst2_tid", {6'b0, sif.thread_id}, 8'd2);

    // Threads 0 and 2 only.
    cyc(1'b1, 4'b0101, 1'b0, 0, 0, 1'b0, 0, 1'b0, 0, "rst");
    for (int i = 0; i < 8; i++) begin
      idle(4'b0101, "en0101");
      chk("en0101_st", sif.thread_state, 8'h11);
      if (i >= 1) chk("en0101_tid", {6'b0, sif.thread_id}, 8'(((i - 1) % 2) * 2));
    end

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom % 64) == 0,
          (($urandom % 10) == 0) ? 4'($urandom) : 4'hF,
          ($urandom % 3) == 0, int'($urandom % 4), int'($urandom % 16),
          ($urandom % 4) == 0, int'($urandom % 4),
          ($urandom % 6) == 0, int'($urandom % 4), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/thread_sched.md
THREAD_SCHED -- requirements
Module: thread_sched

Interface
REQ-001 SHALL take clock and reset as: clk  in  1  clock; rst  in  1  reset, synchronous, active-high.
REQ-002 SHALL take thread_en  in  4  per-thread enable mask, bit i = thread i.
REQ-003 SHALL take block_valid  in  1, block_tid  in  2, block_cycles  in  4: request from exu to park thread block_tid for block_cycles cycles.
REQ-004 SHALL take wake_valid  in  1, wake_tid  in  2: external event that wakes thread wake_tid early.
REQ-005 SHALL take halt_valid  in  1, halt_tid  in  2: thread halt_tid executed wfi/ecall and halts.
REQ-006 SHALL drive thread_id  out  2: thread issued to the fetch stage this cycle.
REQ-007 SHALL drive issue_valid  out  1: thread_id is a real issue; 0 means bubble.
REQ-008 SHALL drive thread_state  out  8: 2-bit state per thread, thread i at bits [2i+1:2i].
REQ-009 SHALL drive all_halted  out  1: high when no thread is READY or WAIT.

Function
REQ-010 SHALL keep one state per thread: DISABLED=0, READY=1, WAIT=2, HALTED=3.
REQ-011 SHALL keep a 4-bit wait counter per thread and a 2-bit round-robin pointer rr_ptr (last issued thread).
REQ-012 SHALL, each cycle, select the first READY thread scanning rr_ptr+1, rr_ptr+2, rr_ptr+3, rr_ptr (mod 4), using state registers before this cycle's updates.
REQ-013 SHALL register the selection: thread_id/issue_valid change on the clock edge after selection (latency 1); rr_ptr updates to the selected thread on the same edge.
REQ-014 SHALL, if no thread is READY, set issue_valid=0, hold thread_id and rr_ptr.
REQ-015 SHALL move DISABLED -> READY when the thread's thread_en bit is 1.
REQ-016 SHALL move any state -> DISABLED when the thread's thread_en bit is 0; this overrides all events; counter cleared.
REQ-017 SHALL, on block for an enabled READY thread, move it to WAIT with counter=block_cycles; block_cycles=0 leaves it READY.
REQ-018 SHALL decrement the counter of a WAIT thread every cycle; counter==1 at the edge -> READY (thread stays WAIT exactly block_cycles cycles).
REQ-019 SHALL move WAIT or HALTED -> READY on wake; counter cleared; wake on READY/DISABLED ignored.
REQ-020 SHALL move READY or WAIT -> HALTED on halt; counter cleared.
REQ-021 SHALL apply priority for same-thread simultaneous events: disable > halt > block > wake.
REQ-022 SHALL apply events to different threads in the same cycle independently.
REQ-023 SHALL ignore block on a thread in WAIT (no counter reload) or HALTED.
REQ-024 SHALL compute all_halted combinationally from state registers.

Reset
REQ-025 SHALL on rst set all states DISABLED, counters 0, rr_ptr=3, thread_id=0, issue_valid=0.
REQ-026 SHALL make rst override every concurrent event, including mid-WAIT; first issue occurs no earlier than 2 cycles after rst deasserts (enable, then select).
REQ-027 SHALL start issue from thread 0 after reset when thread 0 is enabled (rr_ptr=3).

Structure
REQ-028 SHALL place the thread-state enum in cpu_types, and NUM_THREADS=4 and TID_W=2 in cpu_config.
REQ-029 SHALL place the 4-way round-robin find-first in one sub-module rr_arbiter (inputs req[4], ptr[2]; outputs grant_valid, grant_id[2]).

Verification
REQ-030 SHALL cover: thread_en=4'hF after reset -> issue_valid=1 with thread_id 0,1,2,3,0,... one per cycle.
REQ-031 SHALL cover: thread_en=4'b0101 -> thread_id alternates 0,2,0,2; threads 1,3 state DISABLED.
REQ-032 SHALL cover: all enabled, block thread 1 with block_cycles=3 -> thread 1 WAIT for 3 cycles, absent from issue, then READY and resumes in rotation.
REQ-033 SHALL cover: halt all four threads -> all_halted=1, issue_valid=0, thread_id held; wake_tid=2 -> only thread 2 issues, every cycle.
REQ-034 SHALL cover: same cycle halt_tid=1 and block_tid=1 -> thread 1 HALTED; same cycle wake_tid=3 (WAIT) and thread_en[3]=0 -> thread 3 DISABLED.
REQ-035 SHALL cover: rst asserted while thread 2 WAIT with counter 7 -> all DISABLED, counters 0, issue_valid=0 next cycle.
